// File: rtl/n64_bus_router_pkg.sv
// Shared N64 bus definitions: device IDs, bus-wide constants, router FSM states
// and the one-hot read-data selector.
package sc64;

    typedef enum logic [2:0] {
        ID_N64_SDRAM      = 3'd0,
        ID_N64_BOOTLOADER = 3'd1,
        ID_N64_FLASHRAM   = 3'd2,
        ID_N64_DD         = 3'd3,
        ID_N64_CFG        = 3'd4
    } e_n64_id;

    localparam int          N64_BUS_DEVICES    = 5;
    localparam logic [15:0] N64_BUS_ERROR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ROUTER_IDLE,
        ROUTER_ISSUE,
        ROUTER_RESP
    } e_router_state;

    // At most one bit of onehot is set, so OR-ing the masked lanes is a plain mux.
    function automatic logic [15:0] select_rdata(
        input logic [N64_BUS_DEVICES-1:0]    onehot,
        input logic [16*N64_BUS_DEVICES-1:0] data
    );
        logic [15:0] result;
        result = '0;
        for (int i = 0; i < N64_BUS_DEVICES; i++) begin
            if (onehot[i]) result = result | data[16*i +: 16];
        end
        return result;
    endfunction

endpackage

// File: rtl/n64_bus_router_watchdog.sv
// Device-ack deadline counter for n64_bus_router; only exists when
// N64_BUS_ROUTER_TIMEOUT_EN is defined.
`ifdef N64_BUS_ROUTER_TIMEOUT_EN
module n64_bus_router_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int                  COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_W-1:0]  LAST    = COUNT_W'(TIMEOUT_CYCLES - 1);

    logic [COUNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the ISSUE cycle whose count is LAST, i.e. the TIMEOUT_CYCLES-th wait cycle.
    assign expired = tick && (count == LAST);

endmodule
`endif

// File: rtl/n64_bus_router.sv
// Routes the single outstanding PI bus transaction to one of five devices by ID.
// Define N64_BUS_ROUTER_TIMEOUT_EN to build the device-ack watchdog.
module n64_bus_router
    import sc64::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic [2:0]                     req_id,
    input  logic [31:0]                    req_address,
    input  logic                           req_write,
    input  logic [15:0]                    req_wdata,
    output logic                           ack,
    output logic [15:0]                    rdata,
    output logic [N64_BUS_DEVICES-1:0]     dev_request,
    output logic [31:0]                    dev_address,
    output logic                           dev_write,
    output logic [15:0]                    dev_wdata,
    input  logic [N64_BUS_DEVICES-1:0]     dev_ack,
    input  logic [16*N64_BUS_DEVICES-1:0]  dev_rdata,
    output logic                           bus_error,
    input  logic                           error_clear
);

    e_router_state              state, state_next;
    logic [N64_BUS_DEVICES-1:0] dev_request_next;
    logic [31:0]                dev_address_next;
    logic                       dev_write_next;
    logic [15:0]                dev_wdata_next;
    logic [15:0]                rdata_next;
    logic                       ack_next;
    logic                       error_set;
    logic                       bus_error_next;

    logic                       id_mapped;
    logic                       sel_ack;
    logic [15:0]                sel_rdata;
    logic                       wd_expired;

    assign id_mapped = int'(req_id) < N64_BUS_DEVICES;

    // dev_request is one-hot on the selected device throughout ISSUE, so it doubles
    // as the ack mask and the read-data select.
    assign sel_ack   = |(dev_ack & dev_request);
    assign sel_rdata = select_rdata(dev_request, dev_rdata);

`ifdef N64_BUS_ROUTER_TIMEOUT_EN
    logic wd_start;
    logic wd_tick;

    assign wd_start = (state == ROUTER_IDLE) && req && id_mapped;
    assign wd_tick  = (state == ROUTER_ISSUE) && !sel_ack;

    n64_bus_router_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (wd_start),
        .tick    (wd_tick),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_next       = state;
        dev_request_next = dev_request;
        dev_address_next = dev_address;
        dev_write_next   = dev_write;
        dev_wdata_next   = dev_wdata;
        rdata_next       = rdata;
        ack_next         = 1'b0;
        error_set        = 1'b0;

        case (state)
            ROUTER_IDLE: begin
                if (req) begin
                    dev_address_next = req_address;
                    dev_write_next   = req_write;
                    dev_wdata_next   = req_wdata;
                    if (id_mapped) begin
                        dev_request_next = N64_BUS_DEVICES'(1) << req_id;
                        state_next       = ROUTER_ISSUE;
                    end else begin
                        rdata_next = N64_BUS_ERROR_DATA;
                        error_set  = 1'b1;
                        ack_next   = 1'b1;
                        state_next = ROUTER_RESP;
                    end
                end
            end

            ROUTER_ISSUE: begin
                // A real ack beats a watchdog expiry landing in the same cycle.
                if (sel_ack) begin
                    dev_request_next = '0;
                    rdata_next       = dev_write ? 16'h0000 : sel_rdata;
                    ack_next         = 1'b1;
                    state_next       = ROUTER_RESP;
                end else if (wd_expired) begin
                    dev_request_next = '0;
                    rdata_next       = N64_BUS_ERROR_DATA;
                    error_set        = 1'b1;
                    ack_next         = 1'b1;
                    state_next       = ROUTER_RESP;
                end
            end

            ROUTER_RESP: begin
                state_next = ROUTER_IDLE;
            end

            default: begin
                state_next = ROUTER_IDLE;
            end
        endcase

        bus_error_next = error_set | (bus_error & ~error_clear);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ROUTER_IDLE;
            ack         <= 1'b0;
            rdata       <= '0;
            dev_request <= '0;
            dev_address <= '0;
            dev_write   <= 1'b0;
            dev_wdata   <= '0;
            bus_error   <= 1'b0;
        end else begin
            state       <= state_next;
            ack         <= ack_next;
            rdata       <= rdata_next;
            dev_request <= dev_request_next;
            dev_address <= dev_address_next;
            dev_write   <= dev_write_next;
            dev_wdata   <= dev_wdata_next;
            bus_error   <= bus_error_next;
        end
    end

endmodule
